// File: rtl/ctrl_gen2_if.sv
// Input/output handshake bundle for the ctrl_gen2 controller.
// The slave side is the controller; the master side is the I/O fabric.
interface ctrl_gen2_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] in_buf;
    logic              out_ack;

    modport master (
        output in_valid,
        output in_data,
        output out_ack,
        input  in_ready,
        input  in_buf
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ack,
        output in_ready,
        output in_buf
    );
endinterface

// File: rtl/ctrl_gen2.sv
// Multi-cycle CPU control unit: fetch wait, decode, execute,
// plus blocking input/output handshakes. Outputs are registered.
module ctrl_gen2 #(
    parameter int DATA_W     = 8,
    parameter int FETCH_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] alu_res,
    ctrl_gen2_if.slave        io,
    output logic [2:0]        estado,
    output logic [1:0]        sel_dt_wr,
    output logic              wr,
    output logic              ld_pc,
    output logic              sel_jmp,
    output logic              sel_desv,
    output logic              ld_output,
    output logic              sel_reg_wr,
    output logic [2:0]        cmd_ula
);

    typedef enum logic [2:0] {
        CLR      = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        IN_WAIT  = 3'd4,
        OUT_WAIT = 3'd5
    } state_t;

    localparam logic [3:0] FW_LOAD = 4'(FETCH_WAIT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       neg;
    logic       zero;
    logic       take;

    assign estado = state;
    assign neg    = alu_res[DATA_W-1];
    assign zero   = (alu_res == '0);

    // Branch condition for the conditional-branch opcodes.
    always_comb begin
        take = 1'b0;
        case (op)
            4'h9:    take = neg;
            4'hA:    take = !neg && !zero;
            4'hB:    take = zero;
            4'hC:    take = !zero;
            default: take = 1'b0;
        endcase
    end

    // Controller FSM; each output is set on the edge entering the
    // state in which it must be visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            cnt         <= FW_LOAD;
            sel_dt_wr   <= 2'b00;
            wr          <= 1'b0;
            ld_pc       <= 1'b0;
            sel_jmp     <= 1'b0;
            sel_desv    <= 1'b0;
            ld_output   <= 1'b0;
            sel_reg_wr  <= 1'b0;
            cmd_ula     <= 3'd0;
            io.in_ready <= 1'b0;
            io.in_buf   <= '0;
        end else begin
            case (state)
                CLR, EXEC: begin
                    state       <= (state == CLR) ? FETCH : CLR;
                    cnt         <= FW_LOAD;
                    sel_dt_wr   <= 2'b00;
                    wr          <= 1'b0;
                    ld_pc       <= 1'b0;
                    sel_jmp     <= 1'b0;
                    sel_desv    <= 1'b0;
                    ld_output   <= 1'b0;
                    sel_reg_wr  <= 1'b0;
                    cmd_ula     <= 3'd0;
                    io.in_ready <= 1'b0;
                end
                FETCH: begin
                    if (cnt == 4'd0) begin
                        state <= DECODE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DECODE: begin
                    case (op)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                            cmd_ula <= op[2:0];
                            wr      <= 1'b1;
                        end
                        4'h7: begin
                            cmd_ula <= 3'd0;
                            wr      <= 1'b1;
                        end
                        4'h8: begin
                            sel_reg_wr <= 1'b1;
                            sel_dt_wr  <= 2'b01;
                            wr         <= 1'b1;
                        end
                        4'hE: begin
                            sel_dt_wr   <= 2'b10;
                            io.in_ready <= 1'b1;
                        end
                        4'hF: begin
                            cmd_ula   <= 3'd0;
                            ld_output <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (op == 4'hE) begin
                        state <= IN_WAIT;
                    end else if (op == 4'hF) begin
                        state <= OUT_WAIT;
                    end else begin
                        state    <= EXEC;
                        ld_pc    <= 1'b1;
                        sel_jmp  <= (op == 4'hD);
                        sel_desv <= take;
                    end
                end
                IN_WAIT: begin
                    if (io.in_valid) begin
                        io.in_buf   <= io.in_data;
                        io.in_ready <= 1'b0;
                        wr          <= 1'b1;
                        ld_pc       <= 1'b1;
                        state       <= EXEC;
                    end
                end
                OUT_WAIT: begin
                    ld_output <= 1'b0;
                    if (io.out_ack) begin
                        ld_pc <= 1'b1;
                        state <= EXEC;
                    end
                end
                default: state <= CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_gen2.sv
// Self-checking bench for ctrl_gen2: an 8-bit/FETCH_WAIT=1 instance
// and a 16-bit/FETCH_WAIT=3 instance, checked against a cycle model.
module tb_ctrl_gen2;

    logic        clk = 1'b0;
    logic        rst8;
    logic        rst16;
    logic [3:0]  op;
    logic [3:0]  op16;
    logic [7:0]  alu8;
    logic [15:0] alu16;

    logic [2:0]  estado8, estado16;
    logic [1:0]  dt8, dt16;
    logic        wr8, pc8, jmp8, desv8, lo8, rw8;
    logic        wr16, pc16, jmp16, desv16, lo16, rw16;
    logic [2:0]  cmd8, cmd16;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_buf = 8'h00;

    ctrl_gen2_if #(.DATA_W(8))  bus8 ();
    ctrl_gen2_if #(.DATA_W(16)) bus16 ();

    ctrl_gen2 #(.DATA_W(8), .FETCH_WAIT(1)) dut8 (
        .clk(clk), .rst(rst8), .op(op), .alu_res(alu8), .io(bus8.slave),
        .estado(estado8), .sel_dt_wr(dt8), .wr(wr8), .ld_pc(pc8),
        .sel_jmp(jmp8), .sel_desv(desv8), .ld_output(lo8),
        .sel_reg_wr(rw8), .cmd_ula(cmd8)
    );

    ctrl_gen2 #(.DATA_W(16), .FETCH_WAIT(3)) dut16 (
        .clk(clk), .rst(rst16), .op(op16), .alu_res(alu16), .io(bus16.slave),
        .estado(estado16), .sel_dt_wr(dt16), .wr(wr16), .ld_pc(pc16),
        .sel_jmp(jmp16), .sel_desv(desv16), .ld_output(lo16),
        .sel_reg_wr(rw16), .cmd_ula(cmd16)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ctrl8();
        return {dt8, wr8, pc8, jmp8, desv8, lo8, rw8, cmd8, bus8.in_ready};
    endfunction

    // Branch taken, from the signed value of the ALU result.
    function automatic bit branch(input logic [3:0] o, input int sv);
        case (o)
            4'h9:    return sv < 0;
            4'hA:    return sv > 0;
            4'hB:    return sv == 0;
            4'hC:    return sv != 0;
            default: return 1'b0;
        endcase
    endfunction

    // Expected control word visible during state st (spec encodings).
    function automatic logic [11:0] model(input int st, input logic [3:0] o,
                                          input logic [7:0] a, input bit first);
        logic [1:0] dt;
        logic [2:0] c;
        bit w, pc, j, dv, lo, rw, ir;
        dt = 0; c = 0; w = 0; pc = 0; j = 0; dv = 0; lo = 0; rw = 0; ir = 0;
        if (st == 4) begin
            dt = 2'b10;
            ir = 1;
        end
        if (st == 5) lo = first;
        if (st == 3) begin
            pc = 1;
            w  = (o >= 1 && o <= 8) || o == 4'hE;
            c  = (o >= 1 && o <= 6) ? o[2:0] : 3'd0;
            rw = (o == 4'h8);
            dt = (o == 4'h8) ? 2'b01 : (o == 4'hE) ? 2'b10 : 2'b00;
            j  = (o == 4'hD);
            dv = branch(o, int'($signed(a)));
        end
        return {dt, w, pc, j, dv, lo, rw, c, ir};
    endfunction

    // One instruction on the 8-bit unit, starting and ending in FETCH.
    task automatic run8(input logic [3:0] o, input logic [7:0] a,
                        input int dly, input logic [7:0] d);
        int seq[$];
        int wk;
        int st;
        logic [11:0] e;
        seq = {1, 2};
        if (o == 4'hE || o == 4'hF)
            for (int k = 0; k <= dly; k++) seq.push_back(o == 4'hE ? 4 : 5);
        seq.push_back(3);
        seq.push_back(0);
        op = o; alu8 = a; bus8.in_data = d;
        bus8.in_valid = 0; bus8.out_ack = 0;
        wk = -1;
        foreach (seq[i]) begin
            st = seq[i];
            if (st == 4 || st == 5) wk++;
            if (st == 2 || st == 4) bus8.in_valid = (o == 4'hE) && (wk == dly || (st == 2 && dly == 0));
            if (st == 2 || st == 5) bus8.out_ack = (o == 4'hF) && (wk == dly || (st == 2 && dly == 0));
            if (st == 3 && o == 4'hE) exp_buf = d;
            e = model(st, o, a, wk == 0);
            n_assert++;
            assert ({estado8, ctrl8(), bus8.in_buf} === {3'(st), e, exp_buf})
            else begin
                n_fail++;
                $error("FAIL run8 op=%h st=%0d got %h/%h/%h exp %h/%h/%h", o, st,
                       estado8, ctrl8(), bus8.in_buf, 3'(st), e, exp_buf);
            end
            @(negedge clk);
        end
    endtask

    // Enter a handshake wait state, then reset in its second cycle.
    task automatic abort8(input logic [3:0] o);
        op = o; bus8.in_valid = 0; bus8.out_ack = 0;
        @(negedge clk);
        @(negedge clk);
        n_assert++;
        assert ({estado8, ctrl8()} === {(o == 4'hE) ? 3'd4 : 3'd5, model((o == 4'hE) ? 4 : 5, o, 8'h00, 1)})
        else begin
            n_fail++;
            $error("FAIL abort_wait op=%h got %h/%h", o, estado8, ctrl8());
        end
        @(negedge clk);
        rst8 = 0;
        #1;
        exp_buf = 8'h00;
        n_assert++;
        assert ({estado8, ctrl8(), bus8.in_buf} === {3'd1, 12'h000, 8'h00})
        else begin
            n_fail++;
            $error("FAIL abort_rst op=%h got %h/%h/%h exp 1/000/00", o, estado8, ctrl8(), bus8.in_buf);
        end
        @(negedge clk);
        rst8 = 1;
    endtask

    // One non-I/O instruction on the 16-bit, FETCH_WAIT=3 unit.
    task automatic run16(input logic [3:0] o, input logic [15:0] a);
        int seq[$];
        bit dv;
        seq = {1, 1, 1, 2, 3, 0};
        op16 = o; alu16 = a;
        foreach (seq[i]) begin
            dv = (seq[i] == 3) && branch(o, int'($signed(a)));
            n_assert++;
            assert ({estado16, desv16, pc16} === {3'(seq[i]), dv, seq[i] == 3})
            else begin
                n_fail++;
                $error("FAIL run16 op=%h alu=%h cyc=%0d got %h/%b/%b exp %0d/%b/%b", o, a, i,
                       estado16, desv16, pc16, seq[i], dv, seq[i] == 3);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst8 = 0; rst16 = 0;
        op = 0; op16 = 0; alu8 = 0; alu16 = 0;
        bus8.in_valid = 0; bus8.in_data = 0; bus8.out_ack = 0;
        bus16.in_valid = 0; bus16.in_data = 0; bus16.out_ack = 0;
        @(negedge clk);
        @(negedge clk);
        n_assert++;
        assert ({estado8, ctrl8(), bus8.in_buf} === {3'd1, 12'h000, 8'h00})
        else begin
            n_fail++;
            $error("FAIL reset8 got %h/%h/%h exp 1/000/00", estado8, ctrl8(), bus8.in_buf);
        end
        n_assert++;
        assert ({estado16, dt16, wr16, pc16, jmp16, desv16, lo16, rw16, cmd16,
                 bus16.in_ready, bus16.in_buf} === {3'd1, 12'h000, 16'h0000})
        else begin
            n_fail++;
            $error("FAIL reset16 got st=%h buf=%h", estado16, bus16.in_buf);
        end
        rst8 = 1;

        run8(4'h1, 8'h00, 0, 8'h00);
        run8(4'hA, 8'h00, 0, 8'h00);
        run8(4'hA, 8'h05, 0, 8'h00);
        run8(4'h9, 8'h80, 0, 8'h00);
        run8(4'hE, 8'h00, 5, 8'hA5);
        run8(4'hE, 8'h00, 0, 8'h3C);
        run8(4'hF, 8'h00, 0, 8'h00);
        run8(4'hF, 8'h00, 2, 8'h00);
        run8(4'h8, 8'h00, 0, 8'h00);
        run8(4'hD, 8'h00, 0, 8'h00);
        abort8(4'hF);
        run8(4'hE, 8'h00, 1, 8'h5A);
        abort8(4'hE);
        for (int i = 0; i < 40; i++)
            run8(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3), 8'($urandom));

        rst16 = 1;
        run16(4'h9, 16'h8000);
        run16(4'h9, 16'h0080);
        run16(4'hA, 16'h0000);
        run16(4'hB, 16'h0000);
        for (int i = 0; i < 12; i++)
            run16(4'($urandom_range(0, 13)), 16'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
